// File: rtl/viterbi_frame_ctrl_pkg.sv
// Shared types and constants for the Viterbi frame sequencer.
package viterbi_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_TAIL,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int TAIL_SYMS_DEF   = 2;
    localparam int BYTE_W          = 8;
    localparam int MAX_DEC_LATENCY = 4;
    // Wide enough for 7 packer bits plus MAX_DEC_LATENCY payload tags in flight.
    localparam int FILL_W          = 4;

    typedef struct packed {
        logic xfer;
        logic payload;
    } tag_t;

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol, decoder and byte-stream handshake bundle of the frame sequencer.
interface viterbi_frame_ctrl_if;
    import viterbi_ctrl_pkg::*;

    logic              sym_valid;
    logic [1:0]        sym_data;
    logic              sym_ready;
    logic              dec_ready;
    logic [1:0]        dec_x_encoded;
    logic              dec_rst_n;
    logic              dec_out_bit;
    logic              out_valid;
    logic [BYTE_W-1:0] out_data;
    logic              out_ready;

    modport master (
        input  sym_valid, sym_data, dec_out_bit, out_ready,
        output sym_ready, dec_ready, dec_x_encoded, dec_rst_n, out_valid, out_data
    );

    modport slave (
        output sym_valid, sym_data, dec_out_bit, out_ready,
        input  sym_ready, dec_ready, dec_x_encoded, dec_rst_n, out_valid, out_data
    );

endinterface

// File: rtl/viterbi_frame_ctrl_packer.sv
// Packs decoded bits LSB-first into bytes behind a single holding register.
module lsb_bit_packer
    import viterbi_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    input  logic              flush_i,
    input  logic              out_ready_i,
    output logic [FILL_W-1:0] fill_o,
    output logic              out_valid_o,
    output logic [BYTE_W-1:0] out_data_o
);

    logic [BYTE_W-2:0] shreg_q, shreg_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            bit_idx_q <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
        if (bit_valid_i) begin
            // The 8th bit goes straight to the holding register; upstream
            // backpressure guarantees it is free or being drained.
            if (bit_idx_q == 3'd7) begin
                hold_d    = {bit_i, shreg_q};
                valid_d   = 1'b1;
                shreg_d   = '0;
                bit_idx_d = '0;
            end else begin
                shreg_d[bit_idx_q] = bit_i;
                bit_idx_d          = bit_idx_q + 3'd1;
            end
        end else if (flush_i && (bit_idx_q != 3'd0) && (!valid_q || out_ready_i)) begin
            hold_d    = {1'b0, shreg_q};
            valid_d   = 1'b1;
            shreg_d   = '0;
            bit_idx_d = '0;
        end
    end

    assign fill_o      = {1'b0, bit_idx_q};
    assign out_valid_o = valid_q;
    assign out_data_o  = hold_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Per-frame sequencer for the K=3 Viterbi decoder: clear, stream payload, flush tail,
// drain the decoder pipeline and emit packed bytes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; no symbols accepted
//   CLEAR   | one-cycle decoder clear (dec_rst_n low)
//   RUN     | payload pairs streamed, gated by packer backpressure
//   TAIL    | TAIL_SYMS flush pairs, decoder output discarded
//   DRAIN   | wait for pipeline empty, pad and emit any partial byte
//   DONE    | one-cycle done pulse
module viterbi_frame_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int DEC_LATENCY = 1,
    parameter int TAIL_SYMS   = TAIL_SYMS_DEF,
    parameter int LEN_W       = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     frame_len,
    output logic                 busy,
    output logic                 done,
    viterbi_frame_ctrl_if.master bus
);

    localparam int TW = (TAIL_SYMS > 1) ? $clog2(TAIL_SYMS) : 1;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [TW-1:0]     tail_cnt_q, tail_cnt_d;
    logic              dec_rst_n_q;
    tag_t              pipe_q [DEC_LATENCY];
    tag_t              pipe_d [DEC_LATENCY];

    logic              sym_ready_c;
    logic              xfer;
    logic              flush_c;
    logic              pipe_busy;
    logic [FILL_W-1:0] inflight;
    logic [FILL_W-1:0] pk_fill;
    logic [FILL_W-1:0] fill_total;
    logic              pk_valid;

    assign xfer       = bus.sym_valid & sym_ready_c;
    assign fill_total = pk_fill + inflight;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            sym_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            dec_rst_n_q <= 1'b0;
            for (int i = 0; i < DEC_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sym_cnt_q   <= sym_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            dec_rst_n_q <= (state_d != S_CLEAR);
            for (int i = 0; i < DEC_LATENCY; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    always_comb begin
        inflight  = '0;
        pipe_busy = 1'b0;
        for (int i = 0; i < DEC_LATENCY; i++) begin
            if (pipe_q[i].payload) inflight = inflight + FILL_W'(1);
            pipe_busy = pipe_busy | pipe_q[i].xfer;
        end
    end

    always_comb begin
        pipe_d[0].xfer    = xfer;
        pipe_d[0].payload = xfer && (state_q == S_RUN);
        for (int i = 1; i < DEC_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sym_cnt_d   = sym_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        sym_ready_c = 1'b0;
        flush_c     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (frame_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d   = frame_len;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                sym_cnt_d  = '0;
                tail_cnt_d = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                // At most 7 payload bits may be committed while a byte is unclaimed.
                sym_ready_c = !pk_valid || (fill_total <= FILL_W'(6));
                if (xfer) begin
                    if (sym_cnt_q == len_q - LEN_W'(1)) begin
                        sym_cnt_d = '0;
                        state_d   = S_TAIL;
                    end else begin
                        sym_cnt_d = sym_cnt_q + LEN_W'(1);
                    end
                end
            end
            S_TAIL: begin
                sym_ready_c = 1'b1;
                if (xfer) begin
                    if (tail_cnt_q == TW'(TAIL_SYMS - 1)) begin
                        tail_cnt_d = '0;
                        state_d    = S_DRAIN;
                    end else begin
                        tail_cnt_d = tail_cnt_q + TW'(1);
                    end
                end
            end
            S_DRAIN: begin
                flush_c = !pipe_busy;
                if (!pipe_busy && (pk_fill == '0) && (!pk_valid || bus.out_ready)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    lsb_bit_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .bit_valid_i (pipe_q[DEC_LATENCY-1].payload),
        .bit_i       (bus.dec_out_bit),
        .flush_i     (flush_c),
        .out_ready_i (bus.out_ready),
        .fill_o      (pk_fill),
        .out_valid_o (pk_valid),
        .out_data_o  (bus.out_data)
    );

    assign bus.sym_ready     = sym_ready_c;
    assign bus.dec_ready     = xfer;
    assign bus.dec_x_encoded = bus.sym_data;
    assign bus.dec_rst_n     = dec_rst_n_q;
    assign bus.out_valid     = pk_valid;
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl; decoder stand-in returns sym_data[0] after DEC_LATENCY.
module tb_viterbi_frame_ctrl;
    import viterbi_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] frame_len = '0;
    logic        sv = 1'b0;
    logic [1:0]  sd = '0;
    logic        ordy = 1'b0;
    logic        sel = 1'b0;

    logic        busy_a, done_a, busy_b, done_b;
    logic        a_bit = 1'b0;
    logic [2:0]  b_pipe = '0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    int          xfa = 0;

    always #5 clk = ~clk;

    viterbi_frame_ctrl_if ifa ();
    viterbi_frame_ctrl_if ifb ();

    assign ifa.sym_valid   = sv & !sel;
    assign ifa.sym_data    = sd;
    assign ifa.out_ready   = ordy;
    assign ifa.dec_out_bit = a_bit;
    assign ifb.sym_valid   = sv & sel;
    assign ifb.sym_data    = sd;
    assign ifb.out_ready   = ordy;
    assign ifb.dec_out_bit = b_pipe[2];

    viterbi_frame_ctrl #(.DEC_LATENCY(1), .TAIL_SYMS(2), .LEN_W(12)) dut_a (
        .clk(clk), .rst(rst), .start(start & !sel), .frame_len(frame_len),
        .busy(busy_a), .done(done_a), .bus(ifa)
    );

    viterbi_frame_ctrl #(.DEC_LATENCY(3), .TAIL_SYMS(2), .LEN_W(12)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .frame_len(frame_len),
        .busy(busy_b), .done(done_b), .bus(ifb)
    );

    always @(posedge clk) begin
        a_bit  <= ifa.dec_x_encoded[0];
        b_pipe <= {b_pipe[1:0], ifb.dec_x_encoded[0]};
        if (ifa.out_valid && ifa.out_ready) qa.push_back(ifa.out_data);
        if (ifb.out_valid && ifb.out_ready) qb.push_back(ifb.out_data);
        if (ifa.dec_ready) xfa <= xfa + 1;
    end

    function automatic logic cur_ready();
        return sel ? ifb.sym_ready : ifa.sym_ready;
    endfunction

    function automatic logic cur_done();
        return sel ? done_b : done_a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents n pairs whose bit 0 is bits[i]; returns on the negedge after the last transfer.
    task automatic send(input int n, input logic [31:0] bits);
        for (int i = 0; i < n; i++) begin
            int cyc;
            cyc = 0;
            sv  = 1'b1;
            sd  = {1'b0, bits[i]};
            while (!cur_ready() && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("send_ready", cur_ready(), 1);
            if (!cur_ready()) break;
            @(negedge clk);
        end
        sv = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!cur_done() && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, cur_done(), 1);
    endtask

    task automatic pulse_start(input logic [11:0] len);
        frame_len = len;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_sym_ready", ifa.sym_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_data", ifa.out_data, 8'h00);
        chk("rst_done", done_a, 0);
        chk("rst_dec_rst_n", ifa.dec_rst_n, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_dec_rst_n", ifa.dec_rst_n, 1);

        // frame_len=8, decoder bits 1,0,1,1,0,0,1,0 then tail 1,1 -> 0x4D
        base = qa.size();
        b0   = xfa;
        pulse_start(12'd8);
        chk("t1_clear_pulse", ifa.dec_rst_n, 0);
        chk("t1_busy", busy_a, 1);
        @(negedge clk);
        chk("t1_clear_end", ifa.dec_rst_n, 1);
        send(10, 32'h34D);
        chk("t1_xfers", xfa - b0, 10);
        chk("t1_ready_low", ifa.sym_ready, 0);
        @(negedge clk);
        chk("t1_valid", ifa.out_valid, 1);
        chk("t1_data", ifa.out_data, 8'h4D);
        chk("t1_no_done_yet", done_a, 0);
        ordy = 1'b1;
        @(negedge clk);
        chk("t1_done", done_a, 1);
        chk("t1_valid_clr", ifa.out_valid, 0);
        chk("t1_nbytes", qa.size() - base, 1);
        chk("t1_byte", qa[base], 8'h4D);
        @(negedge clk);
        chk("t1_done_pulse", done_a, 0);
        chk("t1_idle_busy", busy_a, 0);

        // frame_len=3, all-ones payload and tail -> tail discarded, zero padded 0x07
        base = qa.size();
        pulse_start(12'd3);
        send(5, 32'h1F);
        wait_done("t2_done");
        chk("t2_nbytes", qa.size() - base, 1);
        chk("t2_byte", qa[base], 8'h07);
        @(negedge clk);
        chk("t2_busy_low", busy_a, 0);

        // frame_len=16 with out_ready held low for 20 cycles after start
        ordy = 1'b0;
        base = qa.size();
        b0   = xfa;
        pulse_start(12'd16);
        fork
            send(18, 32'h33CA5);
            begin
                repeat (17) @(negedge clk);
                chk("t3_stall_ready", ifa.sym_ready, 0);
                chk("t3_stall_valid", ifa.out_valid, 1);
                chk("t3_stall_xfers", xfa - b0, 15);
                repeat (2) @(negedge clk);
                ordy = 1'b1;
            end
        join
        wait_done("t3_done");
        chk("t3_nbytes", qa.size() - base, 2);
        chk("t3_byte0", qa[base], 8'hA5);
        chk("t3_byte1", qa[base+1], 8'h3C);

        // frame_len=0 -> straight to DONE
        @(negedge clk);
        base = qa.size();
        pulse_start(12'd0);
        chk("t4_done", done_a, 1);
        chk("t4_no_clear", ifa.dec_rst_n, 1);
        chk("t4_no_ready", ifa.sym_ready, 0);
        @(negedge clk);
        chk("t4_idle", busy_a, 0);
        chk("t4_no_bytes", qa.size() - base, 0);

        // reset for one cycle with sym_cnt=5, then a clean frame_len=8 frame
        pulse_start(12'd8);
        send(5, 32'h1F);
        rst = 1'b0;
        #1;
        chk("t5_valid", ifa.out_valid, 0);
        chk("t5_ready", ifa.sym_ready, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_dec_rst_n", ifa.dec_rst_n, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_dec_rst_n_rel", ifa.dec_rst_n, 1);
        chk("t5_idle", busy_a, 0);
        base = qa.size();
        pulse_start(12'd8);
        send(10, 32'h396);
        wait_done("t5_done");
        chk("t5_nbytes", qa.size() - base, 1);
        chk("t5_byte", qa[base], 8'h96);

        // start re-asserted mid-RUN with a different frame_len must be ignored
        @(negedge clk);
        base = qa.size();
        pulse_start(12'd8);
        send(3, 32'h5);
        pulse_start(12'd2);
        chk("t6_no_clear", ifa.dec_rst_n, 1);
        chk("t6_still_run", ifa.sym_ready, 1);
        send(7, 32'h7C);
        wait_done("t6_done");
        chk("t6_nbytes", qa.size() - base, 1);
        chk("t6_byte", qa[base], 8'hE5);

        // DEC_LATENCY=3 instance must produce identical bytes
        @(negedge clk);
        sel  = 1'b1;
        base = qb.size();
        pulse_start(12'd16);
        send(18, 32'h33CA5);
        wait_done("t7_done");
        chk("t7_nbytes", qb.size() - base, 2);
        chk("t7_byte0", qb[base], 8'hA5);
        chk("t7_byte1", qb[base+1], 8'h3C);

        @(negedge clk);
        ordy = 1'b0;
        base = qb.size();
        pulse_start(12'd16);
        fork
            send(18, 32'h33CA5);
            begin
                repeat (19) @(negedge clk);
                ordy = 1'b1;
            end
        join
        wait_done("t8_done");
        chk("t8_nbytes", qb.size() - base, 2);
        chk("t8_byte0", qb[base], 8'hA5);
        chk("t8_byte1", qb[base+1], 8'h3C);

        @(negedge clk);
        base = qb.size();
        pulse_start(12'd3);
        send(5, 32'h1F);
        wait_done("t9_done");
        chk("t9_nbytes", qb.size() - base, 1);
        chk("t9_byte", qb[base], 8'h07);
        @(negedge clk);
        chk("t9_busy_low", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Frame sequencer for the rate-1/2, K=3 convolutional decoder in the WiFi TX/RX chain.
- Per frame it clears the decoder, streams encoded symbol pairs into it using the decoder's ready strobe, then feeds TAIL_SYMS flush pairs and discards their output.
- Decoded payload bits are packed LSB-first into bytes and delivered on a valid/ready byte stream, with busy and done status.

Parameters:
- DEC_LATENCY, 1: cycles from the dec_ready-high cycle to the matching dec_out_bit being valid (range 1..4).
- TAIL_SYMS, 2: flush symbol pairs per frame (K-1); the decoder output for these is discarded.
- LEN_W, 12: width of frame_len (payload bits per frame).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle frame start; sampled only in IDLE
- frame_len  in  LEN_W  payload bit count; latched on accepted start
- sym_valid  in  1  encoded pair available
- sym_data  in  2  encoded pair, forwarded as x_encoded
- sym_ready  out  1  controller accepts the pair this cycle
- dec_ready  out  1  decoder ready strobe; equals sym_valid & sym_ready (combinational)
- dec_x_encoded  out  2  equals sym_data (combinational)
- dec_rst_n  out  1  registered active-low decoder clear
- dec_out_bit  in  1  decoder out_bit
- out_valid  out  1  output byte valid
- out_data  out  8  output byte, LSB = first decoded bit
- out_ready  in  1  downstream accepts the byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst low, at any time, including mid-frame):
  - state = IDLE; all counters, the pipeline and the packer are cleared.
  - sym_ready=0, out_valid=0, out_data=0, busy=0, done=0.
  - dec_rst_n=0 while rst is low; it goes to 1 on the first clock edge after release.
- States: IDLE, CLEAR, RUN, TAIL, DRAIN, DONE.
- IDLE:
  - If start=1 and frame_len=0: go to DONE (no decoder clear, no symbols).
  - If start=1 and frame_len>0: latch frame_len and go to CLEAR.
  - Symbols are never accepted in IDLE.
  - start in any other state is ignored.
- CLEAR: lasts exactly one cycle; dec_rst_n=0 for that cycle; then RUN.
- RUN:
  - Each transfer (sym_valid & sym_ready) increments sym_cnt and is tagged payload.
  - sym_ready = !out_valid || (fill <= 6).
  - fill = bits held in the packer + payload tags in flight in the latency pipeline.
  - When sym_cnt reaches frame_len on a transfer: go to TAIL and reset sym_cnt.
- TAIL:
  - sym_ready=1 (tail symbols do not add to fill).
  - Transfers are tagged non-payload.
  - After TAIL_SYMS transfers: go to DRAIN.
- Latency pipeline:
  - DEC_LATENCY-deep shift register of {transfer, payload} flags.
  - When the output tap has payload=1, dec_out_bit is shifted into the packer at bit index bit_idx (0..7).
- Packer:
  - When the 8th bit lands, the byte moves to the out_data holding register and out_valid=1.
  - The backpressure rule makes it impossible for a byte to complete while the holding register is full and not being drained.
  - out_valid & out_ready in the same cycle as a completion: the holding register reloads and out_valid stays 1.
  - out_valid stays high and out_data stays stable until out_ready.
- DRAIN:
  - Wait until the pipeline is empty.
  - If the packer holds 1..7 bits, zero-pad the upper bits and emit the byte once the holding register is free.
  - Go to DONE when the packer and holding register are both empty.
- DONE: done=1 for one cycle; then IDLE.
- sym_cnt wraps nowhere; its width is LEN_W.
- Bytes per frame = ceil(frame_len/8).

Decomposition:
- Package viterbi_ctrl_pkg:
  - state enum
  - default TAIL_SYMS=2
  - BYTE_W=8
  - MAX_DEC_LATENCY=4
- Sub-module lsb_bit_packer:
  - shift register, bit_idx and holding register
  - inputs: bit_valid, bit, flush, out_ready
  - outputs: fill count, out_valid/out_data

Test Plan:
- frame_len=8, 10 back-to-back pairs, decoder bits 1,0,1,1,0,0,1,0 -> dec_rst_n low exactly 1 cycle after start; sym_ready low after 10 transfers; one byte 0x4D; done 1 cycle after the byte is accepted.
- frame_len=3, payload bits 1,1,1, tail bits 1,1 -> single byte 0x07 (tail bits discarded, zero pad); busy low after done.
- frame_len=16, out_ready=0 until 20 cycles after start -> sym_ready drops when out_valid=1 and fill=7; after release, bytes arrive in order with no bit lost or duplicated.
- frame_len=0 -> no dec_rst_n pulse, no sym_ready, no output; done asserted 1 cycle after start.
- rst low for 1 cycle mid-RUN (sym_cnt=5) -> next cycle: out_valid=0, sym_ready=0, busy=0, dec_rst_n=0 during reset; a following frame_len=8 frame decodes correctly.
- start asserted again during RUN -> ignored (frame_len not re-latched, no extra dec_rst_n pulse); DEC_LATENCY=3 variant yields the same bytes as DEC_LATENCY=1.
